// File: rtl/rv_pkg.sv
// rv_pkg: RV32 opcode constants, fetch-state encoding and the reset NOP shared by fetch and decode.
package rv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_FULL} fetch_state_e;
endpackage

// File: rtl/fetch_ir_unit_imm_gen.sv
// imm_gen: combinational RV32 immediate decoder, sign-extended to XLEN.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm
);
    logic [6:0] op;
    logic signed [31:0] imm32;
    assign op = ir[6:0];
    always_comb begin
        imm32 = (op == OP_R) ? 32'sd0 :
                (op == OP_I || op == OP_LOAD || op == OP_JALR || op == OP_SYS) ? {{20{ir[31]}}, ir[31:20]} :
                (op == OP_STORE) ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
                (op == OP_BRANCH) ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} :
                (op == OP_LUI || op == OP_AUIPC) ? {ir[31:12], 12'b0} :
                (op == OP_JAL) ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0} :
                32'sd0;
    end
    assign imm = XLEN'(imm32);
endmodule

// File: rtl/fetch_ir_unit.sv
// fetch_ir_unit: PC and IR owner with a one-word prefetch buffer over a req/ready fetch port.
module fetch_ir_unit
    import rv_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_INSN = rv_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            PCWrite,
    input  logic            PCWriteCond,
    input  logic            S_PC,
    input  logic            IRWrite,
    input  logic [XLEN-1:0] alu_out,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ready,
    output logic            fetch_stall,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ir,
    output logic            ir_valid,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm
);
    fetch_state_e st, st_n;
    logic [31:0] buf_q, ir_q;
    logic [XLEN-1:0] pc_q, pc_n;
    logic ir_valid_q, full, hit, ir_load, pc_upd, buf_wr;

    assign full        = st == F_FULL;
    assign hit         = st == F_REQ && mem_ready;
    assign fetch_stall = IRWrite && !(full || hit);
    assign ir_load     = IRWrite && !fetch_stall;
    assign pc_upd      = !fetch_stall && (PCWrite || PCWriteCond);
    // a redirect in the same cycle as mem_ready discards the stale word
    assign buf_wr      = hit && !pc_upd;

    always_comb begin
        pc_n = (PCWriteCond || S_PC) ? alu_out : pc_q + XLEN'(4);
        pc_n[1:0] = 2'b00;
        st_n = pc_upd ? F_REQ : ir_load ? F_IDLE : buf_wr ? F_FULL : st;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st         <= F_REQ;
            pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
            ir_q       <= NOP_INSN;
            ir_valid_q <= 1'b0;
            buf_q      <= '0;
        end else begin
            st <= st_n;
            if (pc_upd) pc_q <= pc_n;
            if (buf_wr) buf_q <= mem_rdata;
            if (ir_load) begin
                ir_q       <= full ? buf_q : mem_rdata;
                ir_valid_q <= 1'b1;
            end
        end
    end

    assign mem_req  = st == F_REQ;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign opcode   = ir_q[6:0];
    assign func3    = ir_q[14:12];
    assign func7    = ir_q[31:25];
    assign rd       = ir_q[11:7];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm (
        .ir  (ir_q),
        .imm (imm)
    );
endmodule

// File: tb/tb_fetch_ir_unit.sv
// tb_fetch_ir_unit: directed fetch/stall/redirect sequences plus a table of decoded instructions.
module tb_fetch_ir_unit;
    logic clk = 1'b0, clr = 1'b0;
    logic PCWrite = 1'b0, PCWriteCond = 1'b0, S_PC = 1'b0, IRWrite = 1'b0, mem_ready = 1'b0;
    logic [31:0] alu_out = '0, mem_rdata = '0;
    logic mem_req, fetch_stall, ir_valid;
    logic [31:0] mem_addr, pc, ir, imm;
    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic [4:0] rd, rs1, rs2;
    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [6:0]  op;
    } vec_t;
    typedef struct {
        vec_t        v;
        logic [31:0] pc;
    } exp_t;
    vec_t tbl[10];
    exp_t sb[$];

    fetch_ir_unit dut (
        .clk(clk), .clr(clr), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .S_PC(S_PC),
        .IRWrite(IRWrite), .alu_out(alu_out), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .fetch_stall(fetch_stall), .pc(pc),
        .ir(ir), .ir_valid(ir_valid), .opcode(opcode), .func3(func3), .func7(func7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic irw, input logic pcw, input logic pcc, input logic spc,
                         input logic rdy, input logic [31:0] rdata, input logic [31:0] alu);
        IRWrite = irw; PCWrite = pcw; PCWriteCond = pcc; S_PC = spc;
        mem_ready = rdy; mem_rdata = rdata; alu_out = alu;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        exp_t e;
        tbl[0] = '{32'h00500093, 32'h0000_0005, 5'd1,  5'd0,  7'h13};
        tbl[1] = '{32'hFE000EE3, 32'hFFFF_FFFC, 5'd29, 5'd0,  7'h63};
        tbl[2] = '{32'h00112623, 32'h0000_000C, 5'd12, 5'd2,  7'h23};
        tbl[3] = '{32'h12345037, 32'h1234_5000, 5'd0,  5'd8,  7'h37};
        tbl[4] = '{32'hFF9FF0EF, 32'hFFFF_FFF8, 5'd1,  5'd31, 7'h6F};
        tbl[5] = '{32'hFFF12283, 32'hFFFF_FFFF, 5'd5,  5'd2,  7'h03};
        tbl[6] = '{32'h002081B3, 32'h0000_0000, 5'd3,  5'd1,  7'h33};
        tbl[7] = '{32'h80000097, 32'h8000_0000, 5'd1,  5'd0,  7'h17};
        tbl[8] = '{32'hFFFFFFFF, 32'h0000_0000, 5'd31, 5'd31, 7'h7F};
        tbl[9] = '{32'hFE112E23, 32'hFFFF_FFFC, 5'd28, 5'd2,  7'h23};

        #1 clr = 1'b1;
        #2;
        chk("reset pc", pc, 32'h0);
        chk("reset ir", ir, 32'h0000_0013);
        chk("reset ir_valid", 32'(ir_valid), 32'h0);
        @(negedge clk) clr = 1'b0;
        @(posedge clk) #1;
        chk("first mem_req", 32'(mem_req), 32'h1);
        chk("first mem_addr", mem_addr, 32'h0);
        chk("first stall", 32'(fetch_stall), 32'h0);

        drive(0, 0, 0, 0, 1, 32'h00500093, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("full mem_req", 32'(mem_req), 32'h0);
        drive(1, 1, 0, 0, 0, 0, 0);
        #1 chk("full stall", 32'(fetch_stall), 32'h0);
        tick;
        chk("t1 ir", ir, 32'h00500093);
        chk("t1 imm", imm, 32'h5);
        chk("t1 rd", 32'(rd), 32'h1);
        chk("t1 pc", pc, 32'h4);
        chk("t1 ir_valid", 32'(ir_valid), 32'h1);
        chk("t1 mem_req", 32'(mem_req), 32'h1);
        chk("t1 mem_addr", mem_addr, 32'h4);

        drive(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("wait stall", 32'(fetch_stall), 32'h1);
            tick;
            chk("wait pc", pc, 32'h4);
            chk("wait ir", ir, 32'h00500093);
        end
        drive(1, 1, 0, 0, 1, 32'h00A00113, 0);
        #1 chk("bypass stall", 32'(fetch_stall), 32'h0);
        tick;
        chk("bypass ir", ir, 32'h00A00113);
        chk("bypass pc", pc, 32'h8);

        drive(0, 1, 1, 0, 0, 0, 32'h0000_0042);
        tick;
        chk("branch pc", pc, 32'h40);
        chk("branch mem_req", 32'(mem_req), 32'h1);
        chk("branch mem_addr", mem_addr, 32'h40);

        drive(0, 1, 0, 1, 1, 32'hDEADBEEF, 32'h100);
        tick;
        chk("redir pc", pc, 32'h100);
        chk("redir mem_req", 32'(mem_req), 32'h1);
        chk("redir mem_addr", mem_addr, 32'h100);
        chk("redir ir", ir, 32'h00A00113);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1 chk("redir dropped", 32'(fetch_stall), 32'h1);
        tick;

        exp_pc = 32'h100;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0, 1, tbl[i].insn, 0);
            exp_pc += 4;
            sb.push_back('{tbl[i], exp_pc});
            tick;
            if (sb.size() == 0) begin
                chk("table scoreboard empty", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("tbl%0d ir", i), ir, e.v.insn);
                chk($sformatf("tbl%0d imm", i), imm, e.v.imm);
                chk($sformatf("tbl%0d rd", i), 32'(rd), 32'(e.v.rd));
                chk($sformatf("tbl%0d rs1", i), 32'(rs1), 32'(e.v.rs1));
                chk($sformatf("tbl%0d opcode", i), 32'(opcode), 32'(e.v.op));
                chk($sformatf("tbl%0d pc", i), pc, e.pc);
            end
        end

        drive(0, 0, 0, 0, 1, 32'h11111111, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("pre-clr full mem_req", 32'(mem_req), 32'h0);
        #1 clr = 1'b1;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async ir", ir, 32'h0000_0013);
        chk("async ir_valid", 32'(ir_valid), 32'h0);
        chk("async mem_req", 32'(mem_req), 32'h1);
        @(negedge clk) clr = 1'b0;
        tick;
        chk("post-clr mem_addr", mem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
